// File: rtl/vd_frame_ctrl.sv
// Frame sequencer for a Viterbi decoder: paces code symbols onto the decoder at a
// fixed symbol rate, appends a zero tail, drains traceback and collects decoded bits.
module vd_frame_ctrl #(
  parameter int WD_CODE     = 2,
  parameter int K           = 9,
  parameter int TB_LAT      = 40,
  parameter int CYC_PER_SYM = 4,
  parameter int LEN_W       = 10
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               sym_valid,
  input  logic [WD_CODE-1:0] sym_data,
  output logic               sym_ready,
  output logic               dec_active,
  output logic [WD_CODE-1:0] dec_code,
  input  logic               dec_out,
  output logic               bit_valid,
  output logic               bit_data,
  output logic               busy,
  output logic               underrun,
  output logic               frame_done
);

  localparam int PH_W   = $clog2(CYC_PER_SYM);
  // slot must cover the longest frame plus decoder latency and tail
  localparam int SPAN_W = $clog2((1 << LEN_W) + TB_LAT + K) + 1;
  localparam int SLOT_W = (SPAN_W > LEN_W + 8) ? SPAN_W : LEN_W + 8;

  typedef enum logic [2:0] {IDLE, DATA, TAIL, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PH_W-1:0]    phase_reg, phase_next;
  logic [SLOT_W-1:0]  slot_reg, slot_next;
  logic [LEN_W-1:0]   out_cnt_reg, out_cnt_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [WD_CODE-1:0] dec_code_reg, dec_code_next;
  logic               dec_active_reg, dec_active_next;
  logic               bit_valid_reg, bit_valid_next;
  logic               bit_data_reg, bit_data_next;
  logic               underrun_reg, underrun_next;

  logic              phase_last;
  logic              phase_first;
  logic [SLOT_W-1:0] len_ext;
  logic              data_last;
  logic              tail_last;
  logic              capture_ok;

  assign phase_last  = (phase_reg == PH_W'(CYC_PER_SYM - 1));
  assign phase_first = (phase_reg == '0);
  assign len_ext     = SLOT_W'(len_reg);
  assign data_last   = (slot_reg == len_ext - SLOT_W'(1));
  assign tail_last   = (slot_reg == len_ext + SLOT_W'(K - 2));
  assign capture_ok  = phase_last && (slot_reg >= SLOT_W'(TB_LAT)) && (out_cnt_reg < len_reg);

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      slot_reg       <= '0;
      out_cnt_reg    <= '0;
      len_reg        <= '0;
      dec_code_reg   <= '0;
      dec_active_reg <= 1'b0;
      bit_valid_reg  <= 1'b0;
      bit_data_reg   <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      slot_reg       <= slot_next;
      out_cnt_reg    <= out_cnt_next;
      len_reg        <= len_next;
      dec_code_reg   <= dec_code_next;
      dec_active_reg <= dec_active_next;
      bit_valid_reg  <= bit_valid_next;
      bit_data_reg   <= bit_data_next;
      underrun_reg   <= underrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    slot_next       = slot_reg;
    out_cnt_next    = out_cnt_reg;
    len_next        = len_reg;
    dec_code_next   = dec_code_reg;
    dec_active_next = dec_active_reg;
    bit_valid_next  = 1'b0;
    bit_data_next   = bit_data_reg;
    underrun_next   = underrun_reg;

    case (state_reg)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_next    = DATA;
          len_next      = frame_len;
          underrun_next = 1'b0;
          phase_next    = '0;
          slot_next     = '0;
          out_cnt_next  = '0;
          dec_code_next = '0;
        end
      end

      DATA, TAIL, DRAIN: begin
        phase_next = phase_last ? '0 : phase_reg + PH_W'(1);
        slot_next  = slot_reg + {{(SLOT_W-1){1'b0}}, phase_last};

        // The decoder runs on a fixed schedule, so a missing symbol becomes a zero, not a stall
        if (phase_first) begin
          if (state_reg == DATA) begin
            dec_code_next   = sym_valid ? sym_data : '0;
            dec_active_next = 1'b1;
            if (!sym_valid)
              underrun_next = 1'b1;
          end else begin
            dec_code_next = '0;
          end
        end

        if (capture_ok) begin
          bit_valid_next = 1'b1;
          bit_data_next  = dec_out;
          out_cnt_next   = out_cnt_reg + LEN_W'(1);
        end

        if (state_reg == DATA && phase_last && data_last)
          state_next = TAIL;
        else if (state_reg == TAIL && phase_last && tail_last)
          state_next = DRAIN;
        else if (state_reg == DRAIN && out_cnt_reg == len_reg) begin
          state_next      = DONE;
          dec_active_next = 1'b0;
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign sym_ready  = (state_reg == DATA) && phase_first;
  assign dec_active = dec_active_reg;
  assign dec_code   = dec_code_reg;
  assign bit_valid  = bit_valid_reg;
  assign bit_data   = bit_data_reg;
  assign busy       = (state_reg != IDLE);
  assign underrun   = underrun_reg;
  assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_vd_frame_ctrl.sv
// Self-checking bench for vd_frame_ctrl: expected per-cycle outputs are computed
// arithmetically from the cycle index within a frame and the recorded stimulus.
module tb_vd_frame_ctrl;

  localparam int WD_CODE = 2;
  localparam int K       = 9;
  localparam int TB_LAT  = 12;
  localparam int CPS     = 4;
  localparam int LEN_W   = 10;

  logic               CLOCK = 1'b0;
  logic               Reset;
  logic               start;
  logic [LEN_W-1:0]   frame_len;
  logic               sym_valid;
  logic [WD_CODE-1:0] sym_data;
  logic               sym_ready;
  logic               dec_active;
  logic [WD_CODE-1:0] dec_code;
  logic               dec_out;
  logic               bit_valid;
  logic               bit_data;
  logic               busy;
  logic               underrun;
  logic               frame_done;

  vd_frame_ctrl #(
    .WD_CODE(WD_CODE), .K(K), .TB_LAT(TB_LAT), .CYC_PER_SYM(CPS), .LEN_W(LEN_W)
  ) dut (
    .CLOCK(CLOCK), .Reset(Reset), .start(start), .frame_len(frame_len),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .dec_active(dec_active), .dec_code(dec_code), .dec_out(dec_out),
    .bit_valid(bit_valid), .bit_data(bit_data), .busy(busy),
    .underrun(underrun), .frame_done(frame_done)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_pass   = 0;

  int s_val [0:1023];
  int s_dat [0:1023];
  int dout  [0:8191];
  int dir_sym [0:3];
  bit und_m = 1'b0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic drive_random();
    sym_valid = 1'($urandom);
    sym_data  = WD_CODE'($urandom);
    dec_out   = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ready"}, int'(sym_ready), 0);
    check({tag, "_active"}, int'(dec_active), 0);
    check({tag, "_code"}, int'(dec_code), 0);
    check({tag, "_bv"}, int'(bit_valid), 0);
    check({tag, "_bd"}, int'(bit_data), 0);
    check({tag, "_und"}, int'(underrun), 0);
    check({tag, "_done"}, int'(frame_done), 0);
  endtask

  // One idle cycle: outputs checked at this negedge, then inputs for the next edge driven
  task automatic idle_cycle(input bit zero_start);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(sym_ready), 0);
    check("idle_code", int'(dec_code), 0);
    check("idle_bv", int'(bit_valid), 0);
    check("idle_done", int'(frame_done), 0);
    check("idle_und", int'(underrun), int'(und_m));
    drive_random();
    start     = zero_start;
    frame_len = '0;
    @(negedge CLOCK);
  endtask

  // mode 0: random symbols with miss_pct gaps; 1: directed symbols, always valid;
  // 2: always valid except slot 1. abort_t >= 0 asserts Reset in that cycle.
  task automatic run_frame(input int len, input int mode, input int miss_pct, input int abort_t);
    int t_done, strobes, tt, s;
    int exp_code, exp_bv;
    t_done  = ((TB_LAT + len) > (len + K - 1) ? CPS * (TB_LAT + len) : CPS * (len + K - 1)) + 1;
    strobes = 0;
    drive_random();
    start     = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge CLOCK);
    und_m = 1'b0;
    for (int t = 0; t <= t_done + 1; t++) begin
      s        = (t - 1) / CPS;
      exp_code = (t >= 1 && s < len && s_val[s] != 0) ? s_dat[s] : 0;
      tt       = t - CPS * TB_LAT - CPS;
      exp_bv   = (tt >= 0 && (tt % CPS) == 0 && (tt / CPS) < len) ? 1 : 0;
      check("ready", int'(sym_ready), (t < CPS * len && (t % CPS) == 0) ? 1 : 0);
      check("code", int'(dec_code), exp_code);
      check("busy", int'(busy), (t <= t_done) ? 1 : 0);
      check("active", int'(dec_active), (t >= 1 && t < t_done) ? 1 : 0);
      check("done", int'(frame_done), (t == t_done) ? 1 : 0);
      check("bit_valid", int'(bit_valid), exp_bv);
      check("underrun", int'(underrun), int'(und_m));
      if (exp_bv != 0) check("bit_data", int'(bit_data), dout[t - 1]);
      if (bit_valid) strobes++;

      if (t == abort_t) begin
        drive_random();
        Reset = 1'b1;
        start = 1'b0;
        @(negedge CLOCK);
        und_m = 1'b0;
        check_zero("abort");
        Reset = 1'b0;
        $display("frame len=%0d aborted by Reset at t=%0d", len, t);
        return;
      end

      if (mode == 1)      sym_valid = 1'b1;
      else if (mode == 2) sym_valid = (t != CPS);
      else                sym_valid = ($urandom_range(99) >= miss_pct);
      sym_data = (mode == 1 && t / CPS < 4) ? WD_CODE'(dir_sym[t / CPS]) : WD_CODE'($urandom);
      dec_out  = 1'($urandom);
      dout[t]  = int'(dec_out);
      if ((t % CPS) == 0 && t / CPS < len) begin
        s_val[t / CPS] = int'(sym_valid);
        s_dat[t / CPS] = int'(sym_data);
        if (!sym_valid) und_m = 1'b1;
      end
      // Requests while busy must be ignored
      if (t < t_done && $urandom_range(19) == 0) begin
        start     = 1'b1;
        frame_len = LEN_W'($urandom_range(1, 50));
      end else begin
        start = 1'b0;
      end
      @(negedge CLOCK);
    end
    check("strobes", strobes, len);
    $display("frame len=%0d mode=%0d strobes=%0d done_at=%0d underrun=%0d",
             len, mode, strobes, t_done, int'(und_m));
  endtask

  initial begin
    dir_sym[0] = 3; dir_sym[1] = 2; dir_sym[2] = 3; dir_sym[3] = 0;
    Reset = 1'b1;
    drive_random();
    start     = 1'b1;
    frame_len = LEN_W'(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      check_zero("reset");
      drive_random();
      start = 1'($urandom);
    end
    Reset = 1'b0;
    start = 1'b0;
    @(negedge CLOCK);
    $display("reset sequence done");

    idle_cycle(1'b1);
    idle_cycle(1'b0);
    $display("zero-length start ignored");

    run_frame(3, 1, 0, -1);
    idle_cycle(1'b0);

    run_frame(4, 2, 0, -1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    run_frame(6, 0, 0, 9);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    for (int f = 0; f < 10; f++) begin
      run_frame($urandom_range(1, 24), 0, 15, -1);
      idle_cycle(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vd_frame_ctrl.md
Name: vd_frame_ctrl

Overview:
- Frame sequencer in front of VITERBIDECODER. Accepts a frame of rate-1/2 code symbols from an upstream source over a valid/ready handshake, and drives the decoder's Code and Active inputs at a fixed symbol rate.
- Appends K-1 zero tail symbols, then keeps feeding zeros while the traceback drains.
- Collects exactly frame_len decoded bits from DecodeOut and ends the frame with a one-cycle done pulse.

Parameters:
- WD_CODE, 2, code symbol width; matches the decoder.
- K, 9, constraint length; tail = K-1 zero symbols.
- TB_LAT, 40, decoder latency in symbol slots from data slot 0 to the first valid decoded bit; must be >= 1.
- CYC_PER_SYM, 4, CLOCK cycles each symbol is held on dec_code; must be >= 2.
- LEN_W, 10, width of frame_len.

Ports:
- CLOCK  in  1  single clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  frame request; frame_len is sampled with it
- frame_len  in  LEN_W  number of information symbols/bits in the frame
- sym_valid  in  1  upstream symbol valid
- sym_data  in  WD_CODE  upstream code symbol
- sym_ready  out  1  controller accepts sym_data this cycle
- dec_active  out  1  to decoder Active
- dec_code  out  WD_CODE  to decoder Code
- dec_out  in  1  from decoder DecodeOut
- bit_valid  out  1  one-cycle strobe, bit_data is valid
- bit_data  out  1  decoded bit
- busy  out  1  frame in progress
- underrun  out  1  sticky: a data slot had no symbol
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (sampled at a CLOCK edge) values, all outputs 0:
  - state=IDLE; phase, slot and out counters = 0.
  - Reset mid-frame discards the frame; no frame_done is issued.
- Timing base:
  - phase counts 0..CYC_PER_SYM-1 and wraps; each wrap advances slot by 1.
  - slot is a frame-relative index, at least LEN_W+8 bits wide, and must not overflow for frame_len max + TB_LAT.
- FSM states: IDLE, DATA, TAIL, DRAIN, DONE.
- IDLE:
  - When start=1 and frame_len!=0: latch len, clear underrun, clear counters, go to DATA.
  - start with frame_len=0 is ignored.
  - busy=0. dec_code=0.
- DATA (slots 0..len-1):
  - sym_ready = (state==DATA && phase==0), combinational from registers.
  - At the phase-0 edge, dec_code <= sym_valid ? sym_data : 0. dec_code is then held for CYC_PER_SYM cycles.
  - Missing symbol: set underrun; continue with no stall, since decoder timing is fixed.
  - After slot len-1 completes, go to TAIL.
- TAIL: K-1 slots with dec_code=0 and sym_ready=0, then go to DRAIN.
- DRAIN:
  - dec_code=0; slots continue until all bits are collected.
- Bit capture (in any of DATA, TAIL or DRAIN):
  - Capture when phase==CYC_PER_SYM-1, slot>=TB_LAT, and out_cnt<len.
  - bit_data <= dec_out and bit_valid <= 1 for one cycle; out_cnt increments.
  - Bits emerge in order; exactly len bits are produced.
- Leaving DRAIN:
  - When out_cnt reaches len (and the tail is complete), go to DONE.
  - DONE lasts 1 cycle: frame_done=1, then go to IDLE.
  - Exit waits for both: tail finished AND out_cnt==len.
- dec_active:
  - Set on the edge loading slot 0.
  - Cleared on entry to DONE.
- busy: 1 in DATA, TAIL, DRAIN and DONE.
- Busy rules:
  - start while busy is ignored.
  - sym_valid outside sym_ready cycles is ignored (nothing is consumed).
- underrun: sticky until the next accepted start or Reset.
- Simultaneous Reset and start: Reset wins.

Test Plan:
- Reset:
  - Stimulus: Reset=1 for 3 cycles with random inputs.
  - Response: all outputs 0; start during Reset produces no busy.
- Short frame (CYC_PER_SYM=4, K=9, TB_LAT=12):
  - Stimulus: start with frame_len=3; sym_valid always high; symbols 11,10,11.
  - Response: dec_code = 11,10,11, each held 4 cycles; then 00 through slot 14.
  - Response: bit_valid pulses at the ends of slots 12, 13 and 14.
  - Response: frame_done 1 cycle after the third bit; busy falls with it; total of 3 strobes.
- Underrun:
  - Stimulus: frame_len=4; sym_valid low during slot 1's phase 0.
  - Response: dec_code=00 for slot 1; underrun=1 and stays 1 through frame_done.
  - Response: the next start clears underrun.
- Ignored requests:
  - Stimulus: start with frame_len=0.
  - Response: stays IDLE, busy=0.
  - Stimulus: second start while busy.
  - Response: no effect on len or counters.
- Reset mid-DATA:
  - Stimulus: assert Reset at slot 2, phase 1.
  - Response: next cycle busy, dec_active, dec_code and bit_valid are all 0.
  - Response: no frame_done; a new frame afterwards runs normally.
- End-to-end:
  - Stimulus: encode 20 random bits with viterbi_encode9 and feed them through the controller into VITERBIDECODER (TB_LAT set to the decoder's latency).
  - Response: the 20 bit_data strobes equal the input bits.
  - Stimulus: inject 1 symbol error per 5 symbols.
  - Response: output is still error-free.
